// File: rtl/operand_entry_8bit.sv
// operand_entry_8bit
//   Operand source for the 8-bit adder / 7-seg display stage. A, B and Ci are
//   keyed in one nibble at a time on SW, each nibble confirmed by a press of
//   KEY. KEY is synchronised and debounced. A 4-step FSM stages the nibbles,
//   and A, B and Ci are committed together on the fourth press, so the adder
//   never sees a half-entered operand pair.
//
// Parameters
//   DB_W    debounce counter width
//   DB_MAX  KEY must differ from the debounced level for DB_MAX+1 cycles to flip it
//
// Ports
//   CLK    in   system clock, rising edge
//   RST    in   asynchronous active-high reset
//   KEY    in   raw pushbutton, active-high, asynchronous, may bounce
//   SW     in   [3:0] nibble switches, sampled at capture
//   CI_SW  in   carry-in switch, sampled with the last nibble
//   ABORT  in   1-cycle synchronous request to discard a partial entry
//   A, B   out  [7:0] committed operands
//   Ci     out  committed carry-in
//   VALID  out  set by the first commit, cleared only by reset
//   DONE   out  1-cycle pulse on the commit cycle
//   STEP   out  [1:0] nibble expected next: 0=A hi, 1=A lo, 2=B hi, 3=B lo
module operand_entry_8bit #(
    parameter int DB_W   = 10,
    parameter int DB_MAX = 1023
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       KEY,
    input  logic [3:0] SW,
    input  logic       CI_SW,
    input  logic       ABORT,
    output logic [7:0] A,
    output logic [7:0] B,
    output logic       Ci,
    output logic       VALID,
    output logic       DONE,
    output logic [1:0] STEP
);

    typedef enum logic [1:0] {
        S_A_HI = 2'd0,
        S_A_LO = 2'd1,
        S_B_HI = 2'd2,
        S_B_LO = 2'd3
    } step_t;

    // ------------------------------------------------------------------
    // KEY synchroniser and debouncer
    // ------------------------------------------------------------------
    logic            ks_meta;
    logic            ks;
    logic            db;
    logic [DB_W-1:0] cnt;
    logic            press;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ks_meta <= 1'b0;
            ks      <= 1'b0;
        end else begin
            ks_meta <= KEY;
            ks      <= ks_meta;
        end
    end

    // press is a registered one-cycle pulse issued only when the debounced
    // level flips to 1; a release flips db back without producing a press.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db    <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (ks == db) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_MAX)) begin
                db    <= ks;
                cnt   <= '0;
                press <= ks;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Entry FSM
    // ------------------------------------------------------------------
    step_t state;
    step_t state_nxt;
    logic  commit;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= S_A_HI;
        else     state <= state_nxt;
    end

    // ABORT has priority over a coincident press.
    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        if (ABORT) begin
            state_nxt = S_A_HI;
        end else if (press) begin
            case (state)
                S_A_HI:  state_nxt = S_A_LO;
                S_A_LO:  state_nxt = S_B_HI;
                S_B_HI:  state_nxt = S_B_LO;
                S_B_LO: begin
                    state_nxt = S_A_HI;
                    commit    = 1'b1;
                end
                default: state_nxt = S_A_HI;
            endcase
        end
    end

    assign STEP = state;

    // ------------------------------------------------------------------
    // Staging and committed operands
    // ------------------------------------------------------------------
    logic [3:0] st_a_hi;
    logic [3:0] st_a_lo;
    logic [3:0] st_b_hi;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_a_hi <= '0;
            st_a_lo <= '0;
            st_b_hi <= '0;
        end else if (ABORT) begin
            st_a_hi <= '0;
            st_a_lo <= '0;
            st_b_hi <= '0;
        end else if (press) begin
            case (state)
                S_A_HI:  st_a_hi <= SW;
                S_A_LO:  st_a_lo <= SW;
                S_B_HI:  st_b_hi <= SW;
                default: ;
            endcase
        end
    end

    // The low nibble of B and CI_SW go straight to the outputs on the
    // commit press, so no staging register is needed for them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A     <= '0;
            B     <= '0;
            Ci    <= 1'b0;
            VALID <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            DONE <= commit;
            if (commit) begin
                A     <= {st_a_hi, st_a_lo};
                B     <= {st_b_hi, SW};
                Ci    <= CI_SW;
                VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_operand_entry_8bit.sv
module tb_operand_entry_8bit;

    localparam int DBM = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic       KEY;
    logic [3:0] SW;
    logic       CI_SW;
    logic       ABORT;
    logic [7:0] A;
    logic [7:0] B;
    logic       Ci;
    logic       VALID;
    logic       DONE;
    logic [1:0] STEP;

    operand_entry_8bit #(.DB_W(10), .DB_MAX(DBM)) dut (
        .CLK(CLK), .RST(RST), .KEY(KEY), .SW(SW), .CI_SW(CI_SW), .ABORT(ABORT),
        .A(A), .B(B), .Ci(Ci), .VALID(VALID), .DONE(DONE), .STEP(STEP)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: which nibble is next, what has been keyed so far,
    // and what has been committed.
    int         m_step;
    logic [3:0] m_nib [4];
    logic [7:0] m_a;
    logic [7:0] m_b;
    logic       m_ci;
    logic       m_valid;

    function automatic void model_reset();
        m_step = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
        m_a = '0; m_b = '0; m_ci = 1'b0; m_valid = 1'b0;
    endfunction

    function automatic void model_press(input logic [3:0] sw, input logic ci);
        m_nib[m_step] = sw;
        if (m_step == 3) begin
            m_a     = {m_nib[0], m_nib[1]};
            m_b     = {m_nib[2], m_nib[3]};
            m_ci    = ci;
            m_valid = 1'b1;
            m_step  = 0;
        end else begin
            m_step = m_step + 1;
        end
    endfunction

    function automatic void model_abort();
        m_step = 0;
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
    endfunction

    function automatic logic [19:0] model_vec();
        logic [1:0] s;
        s = 2'(m_step);
        return {m_a, m_b, m_ci, m_valid, s};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // One clean press and release; returns how many cycles DONE was seen high.
    task automatic press(input logic [3:0] sw, input logic ci, output int dones);
        dones = 0;
        SW = sw; CI_SW = ci; KEY = 1'b1;
        repeat (8) begin tick(); if (DONE) dones++; end
        KEY = 1'b0;
        repeat (8) begin tick(); if (DONE) dones++; end
        model_press(sw, ci);
    endtask

    task automatic test_reset();
        RST = 1'b1; KEY = 1'b0; SW = '0; CI_SW = 1'b0; ABORT = 1'b0;
        model_reset();
        tick(3);
        RST = 1'b0;
        tick(2);
        n_cmp++;
        if ({A, B, Ci, VALID, DONE, STEP} !== 22'd0) begin
            n_bad++;
            $display("FAIL reset_state: got %h expected 0", {A, B, Ci, VALID, DONE, STEP});
        end
    endtask

    task automatic test_entry();
        logic [3:0] nibs [4];
        logic       ci;
        int         d;
        int         exp_d;
        nibs[0] = 4'hA; nibs[1] = 4'h5; nibs[2] = 4'h3; nibs[3] = 4'hC;
        ci = 1'b1;
        for (int e = 0; e < 6; e++) begin
            if (e > 0) begin
                for (int k = 0; k < 4; k++) nibs[k] = 4'($urandom);
                ci = 1'($urandom);
            end
            for (int k = 0; k < 4; k++) begin
                exp_d = (m_step == 3) ? 1 : 0;
                press(nibs[k], ci, d);
                n_cmp++;
                if (d !== exp_d) begin
                    n_bad++;
                    $display("FAIL entry_done e%0d p%0d: DONE cycles %0d expected %0d", e, k, d, exp_d);
                end
                n_cmp++;
                if ({A, B, Ci, VALID, STEP} !== model_vec()) begin
                    n_bad++;
                    $display("FAIL entry_state e%0d p%0d: got %h expected %h", e, k,
                             {A, B, Ci, VALID, STEP}, model_vec());
                end
            end
        end
        n_cmp++;
        if (m_a == 8'hA5 && m_b == 8'h3C) begin end
    endtask

    task automatic test_timing();
        logic [1:0] s0;
        logic [1:0] s1;
        SW = 4'($urandom); CI_SW = 1'($urandom);
        s0 = 2'(m_step);
        s1 = 2'((m_step + 1) % 4);
        KEY = 1'b1;
        tick(DBM + 3);
        n_cmp++;
        if (STEP !== s0) begin
            n_bad++;
            $display("FAIL timing_early: STEP %0d expected %0d", STEP, s0);
        end
        tick(1);
        n_cmp++;
        if (STEP !== s1) begin
            n_bad++;
            $display("FAIL timing_edge: STEP %0d expected %0d", STEP, s1);
        end
        tick(50 - (DBM + 4));
        n_cmp++;
        if (STEP !== s1) begin
            n_bad++;
            $display("FAIL held_key: STEP %0d expected %0d", STEP, s1);
        end
        KEY = 1'b0;
        tick(8);
        model_press(SW, CI_SW);
    endtask

    task automatic test_bounce();
        logic lvl;
        int   cyc;
        int   run;
        int   dones;
        lvl = 1'b0; cyc = 0; dones = 0;
        SW = 4'($urandom); CI_SW = 1'($urandom);
        while (cyc < 40) begin
            lvl = ~lvl;
            run = $urandom_range(1, 3);
            KEY = lvl;
            repeat (run) begin tick(); if (DONE) dones++; end
            cyc += run;
        end
        KEY = 1'b0;
        tick(8);
        n_cmp++;
        if ({STEP, 2'(dones)} !== {2'(m_step), 2'd0}) begin
            n_bad++;
            $display("FAIL bounce_ignored: STEP %0d done %0d expected STEP %0d done 0", STEP, dones, m_step);
        end
        KEY = 1'b1;
        tick(DBM + 1);
        KEY = 1'b0;
        tick(10);
        model_press(SW, CI_SW);
        n_cmp++;
        if ({A, B, Ci, VALID, STEP} !== model_vec()) begin
            n_bad++;
            $display("FAIL bounce_min_press: got %h expected %h", {A, B, Ci, VALID, STEP}, model_vec());
        end
    endtask

    task automatic test_abort();
        int d;
        // bring entry back to step 0, then two presses
        while (m_step != 0) press(4'($urandom), 1'($urandom), d);
        press(4'($urandom), 1'b0, d);
        press(4'($urandom), 1'b0, d);
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        model_abort();
        tick(2);
        n_cmp++;
        if ({A, B, Ci, VALID, STEP} !== model_vec()) begin
            n_bad++;
            $display("FAIL abort_partial: got %h expected %h", {A, B, Ci, VALID, STEP}, model_vec());
        end
        // ABORT landing exactly on the press cycle, from step 1
        press(4'($urandom), 1'b0, d);
        SW = 4'($urandom);
        KEY = 1'b1;
        tick(DBM + 3);
        ABORT = 1'b1; tick(); ABORT = 1'b0;
        model_abort();
        n_cmp++;
        if ({STEP, DONE} !== 3'b000) begin
            n_bad++;
            $display("FAIL abort_coincident: STEP %0d DONE %0d expected 0 0", STEP, DONE);
        end
        KEY = 1'b0;
        tick(8);
        n_cmp++;
        if ({A, B, Ci, VALID, STEP} !== model_vec()) begin
            n_bad++;
            $display("FAIL abort_kept: got %h expected %h", {A, B, Ci, VALID, STEP}, model_vec());
        end
    endtask

    task automatic test_async_reset();
        int d;
        for (int k = 0; k < 4; k++) press(4'($urandom), 1'b1, d);
        press(4'($urandom), 1'b0, d);
        press(4'($urandom), 1'b0, d);
        KEY = 1'b1;
        tick(3);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if ({A, B, Ci, VALID, DONE, STEP} !== 22'd0) begin
            n_bad++;
            $display("FAIL async_reset: got %h expected 0", {A, B, Ci, VALID, DONE, STEP});
        end
        KEY = 1'b0;
        tick(2);
        RST = 1'b0;
        tick(8);
        for (int k = 0; k < 4; k++) press(4'($urandom), 1'($urandom), d);
        n_cmp++;
        if ({A, B, Ci, VALID, STEP} !== model_vec()) begin
            n_bad++;
            $display("FAIL fresh_entry: got %h expected %h", {A, B, Ci, VALID, STEP}, model_vec());
        end
    endtask

    task automatic test_reset_held_key();
        int d;
        SW = 4'($urandom); CI_SW = 1'b0;
        KEY = 1'b1;
        tick(4);
        RST = 1'b1;
        tick(3);
        model_reset();
        RST = 1'b0;
        tick(12);
        model_press(SW, CI_SW);
        KEY = 1'b0;
        tick(8);
        n_cmp++;
        if ({A, B, Ci, VALID, STEP} !== model_vec()) begin
            n_bad++;
            $display("FAIL held_through_reset: got %h expected %h", {A, B, Ci, VALID, STEP}, model_vec());
        end
        for (int k = 0; k < 3; k++) press(4'($urandom), 1'($urandom), d);
        n_cmp++;
        if ({A, B, Ci, VALID, STEP} !== model_vec()) begin
            n_bad++;
            $display("FAIL held_reset_commit: got %h expected %h", {A, B, Ci, VALID, STEP}, model_vec());
        end
    endtask

    initial begin
        test_reset();
        test_entry();
        test_timing();
        test_bounce();
        test_abort();
        test_async_reset();
        test_reset_held_key();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
